// File: rtl/multisim_pull_arbiter.sv
// Purpose: shares one pull-style source among NUM_PORTS consumers via a one-entry hold register and round-robin grants.
// Latency: 1 cycle from source to consumer (registered). The first beat of a grant comes at least 1 cycle after the request.
// Backpressure: src_rdy is high when the hold register is empty or is draining this cycle. A release costs one IDLE cycle.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   src_vld/src_rdy     source handshake; src_data is captured on src_vld && src_rdy
//   src_data            source payload
//   cons_rdy[i]         consumer i requests a grant and is ready to take a beat
//   cons_vld[i]         beat offered to consumer i; at most one bit is set
//   cons_data           shared payload bus, always equal to the hold register
//   grant_id            current grant, or the last grant while idle
//   busy                high while a consumer holds the grant
module multisim_pull_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          src_vld,
  input  logic [DATA_WIDTH-1:0]         src_data,
  output logic                          src_rdy,
  input  logic [NUM_PORTS-1:0]          cons_rdy,
  output logic [NUM_PORTS-1:0]          cons_vld,
  output logic [DATA_WIDTH-1:0]         cons_data,
  output logic [$clog2(NUM_PORTS)-1:0]  grant_id,
  output logic                          busy
);

  localparam int GW = $clog2(NUM_PORTS);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t                  state_q,      state_d;
  logic                    hold_vld_q,   hold_vld_d;
  logic [DATA_WIDTH-1:0]   hold_data_q,  hold_data_d;
  logic [GW-1:0]           grant_id_q,   grant_id_d;
  logic [GW-1:0]           last_grant_q, last_grant_d;
  logic [BW-1:0]           beat_cnt_q,   beat_cnt_d;

  logic                    xfer;
  logic                    src_acc;
  logic                    release_grant;
  logic                    rr_found;
  logic [GW-1:0]           rr_winner;

  // A beat moves to the consumer only while it holds the grant and is ready.
  assign xfer    = (state_q == ST_GRANT) && hold_vld_q && cons_rdy[grant_id_q];
  // Gating with rst_n keeps the source stalled while reset is asserted.
  assign src_rdy = rst_n && (!hold_vld_q || xfer);
  assign src_acc = src_vld && src_rdy;

  assign cons_data = hold_data_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q == ST_GRANT);

  always_comb begin
    cons_vld = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cons_vld[i] = (state_q == ST_GRANT) && hold_vld_q && (grant_id_q == GW'(i));
    end
  end

  // Hold register. A load takes priority over a drain in the same cycle.
  // Both can happen together, so a full-rate stream has no bubble.
  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    if (src_acc) begin
      hold_vld_d  = 1'b1;
      hold_data_d = src_data;
    end else if (xfer) begin
      hold_vld_d  = 1'b0;
    end
  end

  // Round-robin search. It starts one past the last granted port and wraps,
  // so the port that was just served has the lowest priority next time.
  always_comb begin
    logic [GW-1:0] idx;
    rr_found  = 1'b0;
    rr_winner = last_grant_q;
    idx       = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = GW'((int'(last_grant_q) + k) % NUM_PORTS);
      if (!rr_found && cons_rdy[idx]) begin
        rr_found  = 1'b1;
        rr_winner = idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    last_grant_d  = last_grant_q;
    beat_cnt_d    = beat_cnt_q;
    release_grant = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          grant_id_d = rr_winner;
          beat_cnt_d = '0;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (xfer) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (beat_cnt_q == BW'(MAX_BURST - 1)) begin
            release_grant = 1'b1;
          end
        end else if (!cons_rdy[grant_id_q]) begin
          // The consumer withdrew. Any pending hold entry stays for the next owner.
          release_grant = 1'b1;
        end
        // If the consumer is ready but the register is empty, keep the grant
        // and wait for the source.
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (release_grant) begin
      last_grant_d = grant_id_q;
      beat_cnt_d   = '0;
      state_d      = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      hold_vld_q   <= 1'b0;
      hold_data_q  <= '0;
      grant_id_q   <= '0;
      last_grant_q <= GW'(NUM_PORTS - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      hold_vld_q   <= hold_vld_d;
      hold_data_q  <= hold_data_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // Only the granted port may ever see valid.
  a_cons_vld_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(cons_vld));

endmodule

// File: tb/tb_multisim_pull_arbiter.sv
module tb_multisim_pull_arbiter;
  localparam int NP = 4;
  localparam int DW = 64;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          src_vld = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          src_rdy;
  logic [NP-1:0] cons_rdy = '0;
  logic [NP-1:0] cons_vld;
  logic [DW-1:0] cons_data;
  logic [1:0]    grant_id;
  logic          busy;

  always #5 clk = ~clk;

  multisim_pull_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_vld   (src_vld),
    .src_data  (src_data),
    .src_rdy   (src_rdy),
    .cons_rdy  (cons_rdy),
    .cons_vld  (cons_vld),
    .cons_data (cons_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. The beats currently held are a queue of at most one entry.
  // The owner is a port number, or -1 when no port holds the grant.
  logic [63:0] m_q[$];
  int          m_owner = -1;
  int          m_gid   = 0;
  int          m_last  = NP - 1;
  int          m_beats = 0;

  int          dl_port[$];
  logic [63:0] dl_dat[$];
  bit          last_acc;
  int          idle_full_stall;

  task automatic m_reset();
    m_q.delete();
    m_owner = -1;
    m_gid   = 0;
    m_last  = NP - 1;
    m_beats = 0;
  endtask

  task automatic m_release();
    m_last  = m_owner;
    m_owner = -1;
    m_beats = 0;
  endtask

  task automatic m_update(input logic sv, input logic [63:0] sd, input logic [3:0] cr);
    bit xfer;
    bit acc;
    xfer = (m_owner >= 0) && (m_q.size() > 0) && cr[m_owner];
    acc  = sv && ((m_q.size() == 0) || xfer);
    if (xfer) void'(m_q.pop_front());
    if (acc) m_q.push_back(sd);
    if (m_owner < 0) begin
      for (int k = 1; k <= NP; k++) begin
        int p;
        p = (m_last + k) % NP;
        if (cr[p]) begin
          m_owner = p;
          m_gid   = p;
          m_beats = 0;
          break;
        end
      end
    end else if (xfer) begin
      m_beats++;
      if (m_beats == MB) m_release();
    end else if (!cr[m_owner]) begin
      m_release();
    end
  endtask

  // One clock cycle. Inputs are driven at the negedge and outputs are checked
  // against the model 1 time unit later. The model advances at the posedge.
  task automatic step(input logic rst, input logic sv, input logic [63:0] sd, input logic [3:0] cr);
    bit       xfer;
    logic     e_srdy;
    logic [3:0] e_cvld;
    @(negedge clk);
    rst_n = rst; src_vld = sv; src_data = sd; cons_rdy = cr;
    #1;
    if (!rst) m_reset();
    xfer   = (m_owner >= 0) && (m_q.size() > 0) && cr[m_owner];
    e_srdy = rst && ((m_q.size() == 0) || xfer);
    e_cvld = ((m_owner >= 0) && (m_q.size() > 0)) ? 4'(1 << m_owner) : 4'b0;
    chk("src_rdy", {63'b0, src_rdy}, {63'b0, e_srdy});
    chk("cons_vld", {60'b0, cons_vld}, {60'b0, e_cvld});
    chk("busy", {63'b0, busy}, {63'b0, (m_owner >= 0)});
    chk("grant_id", {62'b0, grant_id}, 64'(m_gid));
    if (e_cvld != 4'b0) chk("cons_data", cons_data, m_q[0]);
    if (xfer) begin
      dl_port.push_back(m_owner);
      dl_dat.push_back(cons_data);
    end
    if (m_owner < 0 && m_q.size() > 0 && !src_rdy) idle_full_stall++;
    last_acc = sv && e_srdy;
    @(posedge clk);
    if (rst) m_update(sv, sd, cr);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 64'h0, 4'b0);
    dl_port.delete();
    dl_dat.delete();
    idle_full_stall = 0;
  endtask

  typedef struct {
    logic        sv;
    logic [63:0] sd;
    logic [3:0]  cr;
    logic        e_srdy;
    logic [3:0]  e_cvld;
    logic        e_busy;
    logic [1:0]  e_gid;
    logic [63:0] e_dat;
  } vec_t;

  vec_t vt[8];

  initial begin
    int n;
    int rdy_r;

    // In this sequence port 1 withdraws while 0xAB is pending, and port 3 then receives 0xAB first.
    vt[0] = '{1'b0, 64'h00, 4'b0010, 1'b1, 4'b0000, 1'b0, 2'd0, 64'h00};
    vt[1] = '{1'b1, 64'hAB, 4'b0010, 1'b1, 4'b0000, 1'b1, 2'd1, 64'h00};
    vt[2] = '{1'b0, 64'h00, 4'b1000, 1'b0, 4'b0010, 1'b1, 2'd1, 64'hAB};
    vt[3] = '{1'b1, 64'hCD, 4'b1000, 1'b0, 4'b0000, 1'b0, 2'd1, 64'hAB};
    vt[4] = '{1'b1, 64'hCD, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 64'hAB};
    vt[5] = '{1'b0, 64'h00, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 64'hCD};
    vt[6] = '{1'b0, 64'h00, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 64'hCD};
    vt[7] = '{1'b0, 64'h00, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 64'hCD};

    // Reset state, then the first cycle after reset is released.
    do_reset();
    chk("rst_cons_data", cons_data, 64'h0);
    chk("rst_src_rdy", {63'b0, src_rdy}, 64'h0);
    step(1'b1, 1'b0, 64'h0, 4'b0);
    chk("post_rst_src_rdy", {63'b0, src_rdy}, 64'h1);
    chk("post_rst_busy", {63'b0, busy}, 64'h0);

    // A single requester with the source streaming 0x10..0x17.
    do_reset();
    n = 0;
    for (int c = 0; c < 16; c++) begin
      step(1'b1, n < 8, 64'(16 + n), 4'b0100);
      if (last_acc) n++;
    end
    chk("t2_beats", 64'(dl_port.size()), 64'd8);
    for (int i = 0; i < 8 && i < dl_port.size(); i++) begin
      chk("t2_port", 64'(dl_port[i]), 64'd2);
      chk("t2_data", dl_dat[i], 64'(16 + i));
    end
    chk("t2_idle_stall", 64'(idle_full_stall > 0), 64'd1);

    // All ports request: bursts of MB beats in order 0,1,2,3,0.
    do_reset();
    n = 0;
    for (int c = 0; c < 30; c++) begin
      step(1'b1, 1'b1, 64'(256 + n), 4'b1111);
      if (last_acc) n++;
    end
    chk("t3_beats", 64'(dl_port.size() >= 20), 64'd1);
    for (int i = 0; i < 20 && i < dl_port.size(); i++) begin
      chk("t3_port", 64'(dl_port[i]), 64'((i / MB) % NP));
      chk("t3_data", dl_dat[i], 64'(256 + i));
    end

    // Table-driven sequence: the consumer withdraws while data is held.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rst_n = 1'b1; src_vld = vt[i].sv; src_data = vt[i].sd; cons_rdy = vt[i].cr;
      #1;
      chk("tbl_src_rdy", {63'b0, src_rdy}, {63'b0, vt[i].e_srdy});
      chk("tbl_cons_vld", {60'b0, cons_vld}, {60'b0, vt[i].e_cvld});
      chk("tbl_busy", {63'b0, busy}, {63'b0, vt[i].e_busy});
      chk("tbl_grant_id", {62'b0, grant_id}, {62'b0, vt[i].e_gid});
      chk("tbl_cons_data", cons_data, vt[i].e_dat);
      @(posedge clk);
      m_update(vt[i].sv, vt[i].sd, vt[i].cr);
    end

    // The granted port waits with the source idle, and then data arrives.
    do_reset();
    step(1'b1, 1'b0, 64'h0, 4'b0010);
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 1'b0, 64'h0, 4'b0010);
      chk("t5_busy", {63'b0, busy}, 64'h1);
      chk("t5_cons_vld", {60'b0, cons_vld}, 64'h0);
      chk("t5_grant_id", {62'b0, grant_id}, 64'd1);
    end
    step(1'b1, 1'b1, 64'h55, 4'b0010);
    step(1'b1, 1'b0, 64'h0, 4'b0010);
    chk("t5_delivered", 64'(dl_dat.size() == 1 && dl_dat[0] == 64'h55 && dl_port[0] == 1), 64'd1);

    // Reset is asserted in the middle of port 0's burst.
    do_reset();
    n = 0;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b1, 64'(512 + n), 4'b1111);
      if (last_acc) n++;
    end
    step(1'b0, 1'b1, 64'h99, 4'b1111);
    chk("t6_rst_busy", {63'b0, busy}, 64'h0);
    chk("t6_rst_cons_vld", {60'b0, cons_vld}, 64'h0);
    chk("t6_rst_cons_data", cons_data, 64'h0);
    step(1'b1, 1'b0, 64'h0, 4'b1111);
    chk("t6_idle_src_rdy", {63'b0, src_rdy}, 64'h1);
    chk("t6_idle_busy", {63'b0, busy}, 64'h0);
    step(1'b1, 1'b0, 64'h0, 4'b1111);
    chk("t6_regrant_port0", {62'b0, grant_id}, 64'd0);
    chk("t6_hold_empty", {60'b0, cons_vld}, 64'h0);

    // Randomized traffic checked against the model, with occasional resets.
    do_reset();
    rdy_r = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) rdy_r = $urandom_range(0, 15);
      step($urandom_range(0, 499) != 0, $urandom_range(0, 3) != 0,
           {$urandom, $urandom}, 4'(rdy_r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
